rgb_window_3x3: RTL and testbench
=================================

Name: rgb_window_3x3

Overview:
- Upstream neighbour of the transmission-estimation stage. Converts a raster-order RGB pixel stream into 3x3 neighbourhoods for the 9-input min/max datapaths.
- Holds two line buffers per channel and a 3-column shift window.
- Emits one fully populated window per accepted input pixel once the window lies entirely inside the image.
- Border windows are never emitted, so the output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

Parameters:
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
COL_W, 10, column counter width (>= clog2(IMG_WIDTH))
ROW_W, 9, row counter width (>= clog2(IMG_HEIGHT))

Ports:
clock  input  1  single clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel present this cycle; no backpressure
in_sof  input  1  qualifies the first pixel of a frame; sampled only when in_valid=1
in_r  input  8  red
in_g  input  8  green
in_b  input  8  blue
r_win  output  72  red window; tap k (1..9) at [8k-1:8k-8]
g_win  output  72  green window, same packing
b_win  output  72  blue window, same packing
win_valid  output  1  windows valid this cycle; drives downstream Enable
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: win_valid=0, frame_done=0, r_win/g_win/b_win=0, col=0, row=0, window registers=0. Line-buffer RAM contents are not reset; validity gating makes them don't-care.
- Tap order is row-major: tap1 = top-left (row-2, col-2), tap5 = centre (row-1, col-1), tap9 = bottom-right = the pixel just accepted.
- Each accepted pixel (in_valid=1) in one cycle:
  - reads line buffers at address col (lb1 = two lines ago, lb0 = one line ago);
  - writes lb1[col] <= lb0[col] and lb0[col] <= incoming pixel;
  - shifts the window left by one column, loading the new right column {lb1, lb0, incoming}.
- Line buffers: depth IMG_WIDTH, 24-bit, one per age. Read-before-write at the same address in the same cycle is required.
- Cycles with in_valid=0: window, counters and outputs hold, except win_valid and frame_done, which are forced 0.
- Latency: win_valid asserts exactly 1 cycle after an accepted pixel with row>=2 and col>=2 (pre-increment counters), and presents that pixel's window.
- Windows never straddle a line wrap; the col>=2 gate guarantees this.
- Counter update: col increments per accepted pixel. At col=IMG_WIDTH-1: col->0, row++.
- End of frame: at row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, row->0, col->0 and frame_done pulses 1 cycle later. The next frame proceeds without in_sof.
- in_sof with in_valid=1 at any position forces that pixel to be (row 0, col 0): counters resync, and no win_valid results from it.
  - Stale line-buffer data is never exposed, because row<2 blocks validity.
  - in_sof at (0,0) during normal flow is a no-op.
- An in_sof that truncates a frame suppresses frame_done for the truncated frame.
- Async reset mid-frame: all outputs 0 immediately. Stream restarts at (0,0) on the first accepted pixel after release, with or without in_sof.
- Throughput: 1 pixel/cycle sustained. Arbitrary in_valid gaps are legal, including mid-line and between frames.
- Pure data movement: no arithmetic on pixel values.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, continuous valid; pixel(row,col) r=16*row+col, g=r+0x80, b=~r; in_sof on first pixel.
  -> First win_valid 1 cycle after pixel (2,2).
  -> r_win taps 1..9 = 00,01,02,10,11,12,20,21,22; g_win taps = r+0x80; b_win taps = ~r.
  -> Exactly 6 win_valid pulses per frame; frame_done pulses 1 cycle after pixel (3,4).
- Same stream with in_valid low 3 cycles after every pixel.
  -> Identical window sequence; win_valid never asserts during gaps; frame_done count = 1.
- Two frames back-to-back, in_sof only on frame 1, frame 2 values +0x40.
  -> 12 windows total; frame 2 first window centre r5=0x51 with no frame-1 data in any tap.
- in_sof asserted at pixel (2,3) of frame 1.
  -> No window from that pixel; counters restart; next window 1 cycle after the 13th pixel of the new frame; no frame_done for the truncated frame.
- reset_n pulsed low at pixel (2,1), then stream resumed from (0,0).
  -> Outputs 0 during reset; first subsequent window exactly as in the first scenario.
- IMG_WIDTH=3, IMG_HEIGHT=3 edge case.
  -> Exactly 1 window per frame, centre r5=0x11; frame_done 1 cycle after pixel (2,2).

Source files
------------

// File: rtl/rgb_window_3x3.sv
// rgb_window_3x3: turns a raster RGB stream into 3x3 neighbourhoods for the min/max datapaths.
// Two line buffers hold the previous lines; only windows lying fully inside the image are flagged valid.
module rgb_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [71:0] r_win,
    output logic [71:0] g_win,
    output logic [71:0] b_win,
    output logic        win_valid,
    output logic        frame_done
);
    logic [23:0]      lb0_mem [IMG_WIDTH];
    logic [23:0]      lb1_mem [IMG_WIDTH];
    logic [8:0][23:0] win_q, win_d;
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic             last_col, last_row;
    logic [23:0]      pix;

    assign pix = {in_r, in_g, in_b};

    // in_sof relocates the current pixel to (0,0) before any decision is made
    always_comb begin
        col_cur      = in_sof ? '0 : col_q;
        row_cur      = in_sof ? '0 : row_q;
        last_col     = col_cur == COL_W'(IMG_WIDTH - 1);
        last_row     = row_cur == ROW_W'(IMG_HEIGHT - 1);
        col_d        = !in_valid ? col_q : last_col ? '0 : col_cur + 1'b1;
        row_d        = !in_valid ? row_q : !last_col ? row_cur : last_row ? '0 : row_cur + 1'b1;
        win_valid_d  = in_valid && row_cur >= ROW_W'(2) && col_cur >= COL_W'(2);
        frame_done_d = in_valid && last_col && last_row;
        win_d        = win_q;
        if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
                win_d[3*k]   = win_q[3*k+1];
                win_d[3*k+1] = win_q[3*k+2];
            end
            win_d[2] = lb1_mem[col_cur];
            win_d[5] = lb0_mem[col_cur];
            win_d[8] = pix;
        end
    end

    // Line buffers are unreset RAM; non-blocking writes give read-before-write at col_cur
    always_ff @(posedge clock) begin
        if (in_valid) begin
            lb1_mem[col_cur] <= lb0_mem[col_cur];
            lb0_mem[col_cur] <= pix;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_tap
        assign r_win[8*k+:8] = win_q[k][23:16];
        assign g_win[8*k+:8] = win_q[k][15:8];
        assign b_win[8*k+:8] = win_q[k][7:0];
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_rgb_window_3x3.sv
// tb_rgb_window_3x3: scoreboard bench for a 5x4 and a 3x3 instance of rgb_window_3x3.
module tb_rgb_window_3x3;
    typedef struct {
        int          dut;
        int          cyc;
        logic [71:0] r, g, b;
    } win_t;
    typedef struct {
        int dut;
        int cyc;
    } fd_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic a_valid = 1'b0, a_sof = 1'b0, b_valid = 1'b0, b_sof = 1'b0;
    logic [7:0] a_r = '0, a_g = '0, a_b = '0, b_r = '0, b_g = '0, b_b = '0;
    logic [71:0] a_rw, a_gw, a_bw, b_rw, b_gw, b_bw;
    logic a_wv, a_fd, b_wv, b_fd;

    win_t wq[$];
    fd_t  fq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   nwin = 0;
    int   nfd = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    rgb_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .COL_W(3), .ROW_W(2)) u_a (
        .clock(clock), .reset_n(reset_n), .in_valid(a_valid), .in_sof(a_sof),
        .in_r(a_r), .in_g(a_g), .in_b(a_b), .r_win(a_rw), .g_win(a_gw), .b_win(a_bw),
        .win_valid(a_wv), .frame_done(a_fd));

    rgb_window_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .COL_W(2), .ROW_W(2)) u_b (
        .clock(clock), .reset_n(reset_n), .in_valid(b_valid), .in_sof(b_sof),
        .in_r(b_r), .in_g(b_g), .in_b(b_b), .r_win(b_rw), .g_win(b_gw), .b_win(b_bw),
        .win_valid(b_wv), .frame_done(b_fd));

    function automatic logic [23:0] pix(input int off, input int r, input int c);
        logic [7:0] v;
        v = 8'(off + 16 * r + c);
        return {v, v + 8'h80, ~v};
    endfunction

    function automatic win_t mk(input int d, input int cy, input int off, input int r, input int c);
        win_t e;
        logic [23:0] p;
        e.dut = d;
        e.cyc = cy;
        for (int k = 0; k < 9; k++) begin
            p = pix(off, r - 2 + k / 3, c - 2 + k % 3);
            e.r[8*k+:8] = p[23:16];
            e.g[8*k+:8] = p[15:8];
            e.b[8*k+:8] = p[7:0];
        end
        return e;
    endfunction

    task automatic chk_win(input int d, input logic [71:0] r, input logic [71:0] g, input logic [71:0] b);
        win_t e;
        total++;
        nwin++;
        if (wq.size() == 0) begin
            bad++;
            $display("FAIL win_unexpected dut=%0d cyc=%0d r=%h required no window", d, cyc, r);
        end else begin
            e = wq.pop_front();
            if (e.dut != d || e.cyc != cyc || e.r != r || e.g != g || e.b != b) begin
                bad++;
                $display("FAIL win dut=%0d cyc=%0d r=%h g=%h b=%h required dut=%0d cyc=%0d r=%h g=%h b=%h",
                         d, cyc, r, g, b, e.dut, e.cyc, e.r, e.g, e.b);
            end
        end
    endtask

    task automatic chk_fd(input int d);
        fd_t e;
        total++;
        nfd++;
        if (fq.size() == 0) begin
            bad++;
            $display("FAIL frame_done_unexpected dut=%0d cyc=%0d required no pulse", d, cyc);
        end else begin
            e = fq.pop_front();
            if (e.dut != d || e.cyc != cyc) begin
                bad++;
                $display("FAIL frame_done dut=%0d cyc=%0d required dut=%0d cyc=%0d", d, cyc, e.dut, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (a_wv) chk_win(0, a_rw, a_gw, a_bw);
        if (b_wv) chk_win(1, b_rw, b_gw, b_bw);
        if (a_fd) chk_fd(0);
        if (b_fd) chk_fd(1);
    end

    task automatic chk_zero(input string nm);
        total++;
        if ({a_rw, a_gw, a_bw, a_wv, a_fd, b_rw, b_gw, b_bw, b_wv, b_fd} != '0) begin
            bad++;
            $display("FAIL %s outputs a_r=%h a_g=%h a_wv=%b a_fd=%b b_g=%h b_wv=%b required all zero",
                     nm, a_rw, a_gw, a_wv, a_fd, b_gw, b_wv);
        end
    endtask

    // Called at a negedge; the pixel is accepted at the following posedge
    task automatic send(input int d, input int off, input int r, input int c, input bit sof,
                        input int gap, input int w, input int h);
        logic [23:0] p;
        p = pix(off, r, c);
        if (d == 0) begin
            a_valid = 1'b1; a_sof = sof; {a_r, a_g, a_b} = p;
        end else begin
            b_valid = 1'b1; b_sof = sof; {b_r, b_g, b_b} = p;
        end
        if (r >= 2 && c >= 2) wq.push_back(mk(d, cyc + 1, off, r, c));
        if (r == h - 1 && c == w - 1) fq.push_back('{d, cyc + 1});
        @(negedge clock);
        a_valid = 1'b0; a_sof = 1'b0; b_valid = 1'b0; b_sof = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic frame(input int d, input int off, input int w, input int h, input bit sof, input int gap);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                send(d, off, r, c, sof && r == 0 && c == 0, gap, w, h);
    endtask

    task automatic endscn(input string nm, input int ew, input int ef);
        repeat (3) @(negedge clock);
        total++;
        if (nwin != ew) begin
            bad++;
            $display("FAIL %s win_count got=%0d required=%0d", nm, nwin, ew);
        end
        total++;
        if (nfd != ef) begin
            bad++;
            $display("FAIL %s frame_done_count got=%0d required=%0d", nm, nfd, ef);
        end
        total++;
        if (wq.size() != 0 || fq.size() != 0) begin
            bad++;
            $display("FAIL %s missing win_left=%0d fd_left=%0d required 0 0", nm, wq.size(), fq.size());
        end
        wq.delete();
        fq.delete();
        nwin = 0;
        nfd = 0;
    endtask

    initial begin
        #12 chk_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_zero("after_reset");
        frame(0, 0, 5, 4, 1'b1, 0);
        endscn("continuous", 6, 1);
        frame(0, 0, 5, 4, 1'b1, 3);
        endscn("gaps", 6, 1);
        frame(0, 0, 5, 4, 1'b1, 0);
        frame(0, 8'h40, 5, 4, 1'b0, 0);
        endscn("two_frames", 12, 2);
        for (int i = 0; i < 13; i++) send(0, 0, i / 5, i % 5, i == 0, 0, 5, 4);
        frame(0, 0, 5, 4, 1'b1, 0);
        endscn("sof_truncate", 7, 1);
        for (int i = 0; i < 11; i++) send(0, 0, i / 5, i % 5, i == 0, 0, 5, 4);
        reset_n = 1'b0;
        #1 chk_zero("mid_reset");
        repeat (2) @(negedge clock);
        chk_zero("held_reset");
        reset_n = 1'b1;
        @(negedge clock);
        frame(0, 0, 5, 4, 1'b0, 0);
        endscn("reset_resume", 6, 1);
        frame(1, 0, 3, 3, 1'b1, 0);
        frame(1, 0, 3, 3, 1'b0, 1);
        endscn("small_3x3", 2, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
